// File: rtl/seg_scan.sv
// seg_scan: 4-digit multiplexed seven-segment scan driver (common anode).
// Captures {sign,hex2,hex1,hex0} on load into a staging register and
// commits it to the displayed shadow copy only at frame boundaries.
module seg_scan #(
    parameter int unsigned DIV   = 50000,
    parameter int unsigned BLANK = 16,
    parameter int unsigned LZS   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sign,
    input  logic [3:0] hex2,
    input  logic [3:0] hex1,
    input  logic [3:0] hex0,
    input  logic       load,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       pend,
    output logic       frame
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {
        SLOT0 = 2'd0,
        SLOT1 = 2'd1,
        SLOT2 = 2'd2,
        SLOT3 = 2'd3
    } slot_e;

    logic [CW-1:0] cnt_q, cnt_d;
    slot_e         idx_q, idx_d;
    logic [12:0]   stg_q;
    logic [12:0]   shd_q;
    logic          pend_q;
    logic          frame_q;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;

    logic          tick;
    logic          boundary;
    logic          blank_win;
    logic [12:0]   din;

    logic          sh_sign;
    logic [3:0]    sh_hex2, sh_hex1, sh_hex0;

    assign din      = {sign, hex2, hex1, hex0};
    assign tick     = (cnt_q == CW'(DIV - 1));
    assign boundary = tick && (idx_q == SLOT3);
    assign blank_win = (cnt_q < CW'(BLANK));

    assign {sh_sign, sh_hex2, sh_hex1, sh_hex0} = shd_q;

    // Active-high {g,f,e,d,c,b,a} pattern for one hex digit.
    function automatic logic [6:0] hex_code(input logic [3:0] h);
        case (h)
            4'h0:    hex_code = 7'h3F;
            4'h1:    hex_code = 7'h06;
            4'h2:    hex_code = 7'h5B;
            4'h3:    hex_code = 7'h4F;
            4'h4:    hex_code = 7'h66;
            4'h5:    hex_code = 7'h6D;
            4'h6:    hex_code = 7'h7D;
            4'h7:    hex_code = 7'h07;
            4'h8:    hex_code = 7'h7F;
            4'h9:    hex_code = 7'h6F;
            4'hA:    hex_code = 7'h77;
            4'hB:    hex_code = 7'h7C;
            4'hC:    hex_code = 7'h39;
            4'hD:    hex_code = 7'h5E;
            4'hE:    hex_code = 7'h79;
            default: hex_code = 7'h71;
        endcase
    endfunction

    // Prescaler and slot sequencer: next-state logic.
    always_comb begin
        cnt_d = tick ? '0 : cnt_q + CW'(1);
        idx_d = idx_q;
        if (tick) begin
            case (idx_q)
                SLOT0: idx_d = SLOT1;
                SLOT1: idx_d = SLOT2;
                SLOT2: idx_d = SLOT3;
                SLOT3: idx_d = SLOT0;
            endcase
        end
    end

    // Prescaler and slot sequencer: state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            idx_q <= SLOT0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    // Double buffer: staging follows load, shadow is committed at the frame
    // boundary; a load on the boundary bypasses staging straight into shadow.
    always_ff @(posedge clk) begin
        if (rst) begin
            stg_q   <= '0;
            shd_q   <= '0;
            pend_q  <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            frame_q <= boundary;
            if (load) begin
                stg_q <= din;
            end
            if (boundary) begin
                pend_q <= 1'b0;
                if (load) begin
                    shd_q <= din;
                end else if (pend_q) begin
                    shd_q <= stg_q;
                end
            end else if (load) begin
                pend_q <= 1'b1;
            end
        end
    end

    // Digit content for the current slot, with leading-zero suppression and
    // the anti-ghosting blank window at the start of every slot.
    always_comb begin
        logic       lit;
        logic [3:0] an_sel;
        logic [6:0] code;
        lit    = 1'b0;
        an_sel = 4'hF;
        code   = '0;
        an_d   = '1;
        seg_d  = '1;
        case (idx_q)
            SLOT0: begin
                code   = hex_code(sh_hex0);
                lit    = 1'b1;
                an_sel = 4'b1110;
            end
            SLOT1: begin
                code   = hex_code(sh_hex1);
                lit    = !((LZS != 0) && (sh_hex2 == 4'h0) && (sh_hex1 == 4'h0));
                an_sel = 4'b1101;
            end
            SLOT2: begin
                code   = hex_code(sh_hex2);
                lit    = !((LZS != 0) && (sh_hex2 == 4'h0));
                an_sel = 4'b1011;
            end
            SLOT3: begin
                code   = 7'b1000000;
                lit    = sh_sign;
                an_sel = 4'b0111;
            end
        endcase
        if (lit && !blank_win) begin
            an_d  = an_sel;
            seg_d = ~code;
        end
    end

    // Registered display outputs (one cycle behind cnt/idx/shadow).
    always_ff @(posedge clk) begin
        if (rst) begin
            an_q  <= '1;
            seg_q <= '1;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    assign an    = an_q;
    assign seg   = seg_q;
    assign pend  = pend_q;
    assign frame = frame_q;

endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: directed checks of seg_scan with DIV=8, BLANK=2; a second
// instance with LZS=0 runs alongside to cover the non-suppressed display.
module tb_seg_scan;

    localparam int unsigned DIV   = 8;
    localparam int unsigned BLANK = 2;
    localparam logic [12:0] IDLE_IN = 13'h1EDC;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       sign = 1'b0;
    logic [3:0] hex2 = '0;
    logic [3:0] hex1 = '0;
    logic [3:0] hex0 = '0;
    logic       load = 1'b0;

    logic [3:0] an,    an_n;
    logic [6:0] seg,   seg_n;
    logic       pend,  pend_n;
    logic       frame, frame_n;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seg_scan #(.DIV(DIV), .BLANK(BLANK), .LZS(1)) u_dut (
        .clk(clk), .rst(rst), .sign(sign), .hex2(hex2), .hex1(hex1), .hex0(hex0),
        .load(load), .an(an), .seg(seg), .pend(pend), .frame(frame)
    );

    seg_scan #(.DIV(DIV), .BLANK(BLANK), .LZS(0)) u_dut_nz (
        .clk(clk), .rst(rst), .sign(sign), .hex2(hex2), .hex1(hex1), .hex0(hex0),
        .load(load), .an(an_n), .seg(seg_n), .pend(pend_n), .frame(frame_n)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [12:0] v);
        {sign, hex2, hex1, hex0} = v;
    endtask

    // Called at the negedge of offset 0 of a frame; walks offsets 1..31 and
    // checks every displayed cycle. Slot s is packed at ea[4s+:4], es[7s+:7].
    task automatic run_frame(input string tag,
                             input logic [15:0] ea,  input logic [27:0] es,
                             input logic [15:0] ea2, input logic [27:0] es2,
                             input int l1, input logic [12:0] v1,
                             input int l2, input logic [12:0] v2);
        logic       pl;
        int         s, c;
        logic [3:0] xa, xa2;
        logic [6:0] xs, xs2;
        pl = 1'b0;
        for (int k = 1; k < 32; k++) begin
            @(negedge clk);
            s = (k - 1) / 8;
            c = (k - 1) % 8;
            if (c < int'(BLANK)) begin
                xa = 4'hF; xs = 7'h7F; xa2 = 4'hF; xs2 = 7'h7F;
            end else begin
                xa  = ea[4*s +: 4];
                xs  = es[7*s +: 7];
                xa2 = ea2[4*s +: 4];
                xs2 = es2[7*s +: 7];
            end
            chk($sformatf("%s k%0d an", tag, k), 32'(an), 32'(xa));
            chk($sformatf("%s k%0d seg", tag, k), 32'(seg), 32'(xs));
            chk($sformatf("%s k%0d an_nolzs", tag, k), 32'(an_n), 32'(xa2));
            chk($sformatf("%s k%0d seg_nolzs", tag, k), 32'(seg_n), 32'(xs2));
            chk($sformatf("%s k%0d pend", tag, k), 32'(pend), 32'(pl));
            chk($sformatf("%s k%0d frame", tag, k), 32'(frame), 32'(0));
            load = 1'b0;
            drive(IDLE_IN);
            if (k == l1) begin
                load = 1'b1; drive(v1); pl = 1'b1;
            end
            if (k == l2) begin
                load = 1'b1; drive(v2); pl = 1'b1;
            end
        end
    endtask

    // Advance to offset 0 of the next frame: frame pulses, pend has cleared.
    task automatic next_frame(input string tag);
        @(negedge clk);
        load = 1'b0;
        drive(IDLE_IN);
        chk({tag, " frame"}, 32'(frame), 32'(1));
        chk({tag, " pend"}, 32'(pend), 32'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        // Reset held for three cycles.
        rst = 1'b1;
        drive(IDLE_IN);
        repeat (3) @(negedge clk);
        chk("rst an", 32'(an), 32'(4'hF));
        chk("rst seg", 32'(seg), 32'(7'h7F));
        chk("rst pend", 32'(pend), 32'(0));
        chk("rst frame", 32'(frame), 32'(0));
        chk("rst an_nolzs", 32'(an_n), 32'(4'hF));
        rst = 1'b0;

        // Frame after reset shows "0"; load {1,A,5,3} mid-frame.
        run_frame("post_rst",
                  16'hFFFE, {7'h7F, 7'h7F, 7'h7F, 7'h40},
                  16'hFBDE, {7'h7F, 7'h40, 7'h40, 7'h40},
                  12, 13'h1A53, -1, 13'h0);
        next_frame("bnd1");

        // "-A53" displayed; load {0,0,0,7} mid-frame.
        run_frame("show_a53",
                  16'h7BDE, {7'h3F, 7'h08, 7'h12, 7'h30},
                  16'h7BDE, {7'h3F, 7'h08, 7'h12, 7'h30},
                  9, 13'h0007, -1, 13'h0);
        next_frame("bnd2");

        // Leading zeros suppressed; load {1,C,0,E} on the boundary cycle.
        run_frame("lzs_007",
                  16'hFFFE, {7'h7F, 7'h7F, 7'h7F, 7'h78},
                  16'hFBDE, {7'h7F, 7'h40, 7'h40, 7'h78},
                  31, 13'h1C0E, -1, 13'h0);
        next_frame("bnd_load");

        // Boundary load visible at once; two loads, last one wins.
        run_frame("show_c0e",
                  16'h7BDE, {7'h3F, 7'h46, 7'h40, 7'h06},
                  16'h7BDE, {7'h3F, 7'h46, 7'h40, 7'h06},
                  5, 13'h0123, 20, 13'h0456);
        next_frame("bnd4");

        run_frame("show_456",
                  16'hFBDE, {7'h7F, 7'h19, 7'h12, 7'h02},
                  16'hFBDE, {7'h7F, 7'h19, 7'h12, 7'h02},
                  -1, 13'h0, -1, 13'h0);
        next_frame("bnd5");

        // Load then reset before the boundary: the load is discarded.
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            load = 1'b0;
            drive(IDLE_IN);
            if (k == 6) chk("midrst pend_set", 32'(pend), 32'(1));
            if (k == 11) begin
                chk("midrst pend", 32'(pend), 32'(0));
                chk("midrst an", 32'(an), 32'(4'hF));
                chk("midrst seg", 32'(seg), 32'(7'h7F));
                chk("midrst frame", 32'(frame), 32'(0));
            end
            if (k == 4) begin
                load = 1'b1;
                drive(13'h1999);
            end
            if (k == 10) rst = 1'b1;
            if (k == 12) rst = 1'b0;
        end

        run_frame("after_rst1",
                  16'hFFFE, {7'h7F, 7'h7F, 7'h7F, 7'h40},
                  16'hFBDE, {7'h7F, 7'h40, 7'h40, 7'h40},
                  -1, 13'h0, -1, 13'h0);
        next_frame("bnd6");
        run_frame("after_rst2",
                  16'hFFFE, {7'h7F, 7'h7F, 7'h7F, 7'h40},
                  16'hFBDE, {7'h7F, 7'h40, 7'h40, 7'h40},
                  -1, 13'h0, -1, 13'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seg_scan.md
# seg_scan

Multiplexed 4-digit seven-segment scan driver on the board I/O path. It consumes the latched 1-bit flag and three hex nibbles produced by the button-triggered transmission latch, and drives the common-anode display. Input values are double-buffered and committed only at frame boundaries, so a capture never shows up half-drawn. Includes anti-ghosting blanking and optional leading-zero suppression.

## Interface
- DIV, 50000: prescaler cycles per digit slot; legal range 4..2^20.
- BLANK, 16: cycles at the start of each slot with all anodes off; must be < DIV.
- LZS, 1: 1 enables leading-zero suppression on hex2/hex1; 0 disables it.
- clk  in  1  system clock.
- rst  in  1  reset, synchronous and active-high.
- sign  in  1  flag from latch (y1); 1 shows "-" on digit 3.
- hex2  in  4  most significant nibble (y2), shown on digit 2.
- hex1  in  4  middle nibble (y3), shown on digit 1.
- hex0  in  4  least significant nibble (y4), shown on digit 0.
- load  in  1  1-cycle request to capture {sign,hex2,hex1,hex0}.
- an  out  4  anode enables, active-low; an[i] selects digit i.
- seg  out  7  cathodes {g,f,e,d,c,b,a}, active-low.
- pend  out  1  captured data waiting for the next frame boundary.
- frame  out  1  1-cycle pulse at the first cycle of each new frame.

## Operation
- Prescaler cnt counts 0..DIV-1 and wraps to 0. A tick occurs when cnt==DIV-1.
- Slot index idx counts 0..3 and advances on each tick. At idx==3 the tick wraps it to 0; this is the frame boundary.
- Staging register: load=1 writes the inputs into staging and sets pend.
- Shadow register: the display always reads shadow. At the frame boundary, if pend=1, shadow<=staging and pend is cleared.
- If load coincides with the boundary cycle, the current input values go straight into shadow and staging, and pend ends at 0.
- Slot content for idx=0..2 is the hex digit from shadow hex0/hex1/hex2.
- Slot content for idx=3: if sign=1, digit 3 is lit with g only (seg=7'b0111111). If sign=0, an[3] stays off.
- Leading-zero suppression (LZS=1):
  - digit 2 is blanked (anode off) when hex2==0;
  - digit 1 is blanked when hex2==0 and hex1==0;
  - digit 0 is never blanked.
- Blanking window: all anodes are off while cnt<BLANK, regardless of content. While an anode is off, seg=7'h7F.
- Hex encoding, active-high g..a, with seg = ~code:
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
  - 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
- Reset values: cnt=0, idx=0, staging=0, shadow=0, pend=0, an=4'hF, seg=7'h7F, frame=0.
- Reset has priority over load and over any tick. A reset mid-frame discards the staging contents and the pending request.

## Timing
- an and seg are registered: the value in cycle n+1 is a function of cnt, idx and shadow in cycle n, so there is 1 cycle of latency.
- Digit slots:
  - slot length is exactly DIV cycles;
  - a frame is 4*DIV cycles;
  - lit time per slot is DIV-BLANK cycles.
- frame is registered: it is high in the cycle where idx==0 and cnt==0, i.e. the cycle after the boundary edge.
- pend rises the cycle after load. It falls on the boundary edge, so it is low in the same cycle frame is high.
- Input to display latency: the new shadow is visible on an/seg at the first lit cycle of digit 0 after the boundary, which is BLANK+1 cycles after frame.
- Multiple loads within one frame: the last one wins; pend stays 1.
- The inputs are sampled only on load. Changes while load=0 have no effect.

## Test plan
All scenarios use DIV=8, BLANK=2, LZS=1.

- **Reset:** hold rst 3 cycles. Require an=F, seg=7F, pend=0, frame=0. Release; the first frame shows only digit 0 = "0": an=E, seg=40 from cycle 3 to cycle 8 of the slot.
- **Load mid-frame:** load with sign=1, hex=A,5,3. Require:
  - pend=1 until the boundary;
  - the display stays on the old value;
  - the next frame gives an=E/seg=30 ("3"), an=D/seg=12 ("5"), an=B/seg=08 ("A"), an=7/seg=3F ("-").
- **Leading-zero suppression:** load hex=0,0,7 with sign=0. Require only an=E/seg=78 to light; slots 1, 2 and 3 keep an=F. Repeat with LZS=0: digits 2 and 1 show "0" (seg=40).
- **Load on the boundary:** load exactly in the cycle where idx==3 and cnt==7. Require the new data in shadow immediately, pend=0, and frame=1 in the next cycle.
- **Back-to-back loads:** two loads in the same frame, values 1,2,3 then 4,5,6. Require 4,5,6 to be displayed and 1,2,3 never to appear.
- **Reset mid-operation:** load, then assert rst before the boundary. Require pend=0, the display to return to "0", and the lost load never to appear.
